// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive deframer.
// The ones-run thresholds decide how each received line bit is interpreted.
package hdlc_pkg;

   // Frame-level receive state.
   typedef enum logic [1:0] {
      HUNT = 2'd0,   // waiting for an opening flag
      OPEN = 2'd1,   // flag seen, no data byte emitted yet
      DATA = 2'd2    // at least one byte of the frame emitted
   } state_t;

   // Interpretation of a single received line bit.
   typedef enum logic [1:0] {
      BIT_DATA  = 2'd0,
      BIT_STUFF = 2'd1,
      BIT_FLAG  = 2'd2,
      BIT_ABORT = 2'd3
   } bit_class_t;

   // Run lengths of consecutive ones that give a bit its meaning.
   localparam logic [2:0] STUFF_ONES = 3'd5;  // a 0 after five ones is a stuffed bit
   localparam logic [2:0] FLAG_ONES  = 3'd6;  // a 0 after six ones closes a flag
   localparam logic [2:0] ABORT_ONES = 3'd7;  // a seventh one is an abort

endpackage : hdlc_pkg

// File: rtl/hdlc_bit_classifier.sv
// Tracks the run of consecutive ones on the line and labels each incoming
// bit as data, stuffed zero, flag terminator or abort.
module hdlc_bit_classifier
   import hdlc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_bit,
   output bit_class_t bit_class
);

   logic [2:0] ones_cnt;

   // Run-length counter of ones, saturating at ABORT_ONES; any zero restarts it.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         ones_cnt <= '0;
      end else if (in_valid) begin
         if (!in_bit) begin
            ones_cnt <= '0;
         end else if (ones_cnt != ABORT_ONES) begin
            ones_cnt <= ones_cnt + 3'd1;
         end
      end
   end

   // Classify the current bit from the run length that precedes it.
   // Only the one that completes the seventh counts as an abort; further ones
   // arrive with ones_cnt already at 7 and fall through to data, which the
   // frame FSM ignores because it is hunting by then.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      bit_class = BIT_DATA;
      if (!in_bit && ones_cnt == FLAG_ONES) begin
         bit_class = BIT_FLAG;
      end else if (in_bit && ones_cnt == FLAG_ONES) begin
         bit_class = BIT_ABORT;
      end else if (!in_bit && ones_cnt == STUFF_ONES) begin
         bit_class = BIT_STUFF;
      end
   end

endmodule : hdlc_bit_classifier

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunting, zero destuffing, abort detection,
// LSB-first byte assembly and frame delimiting. All outputs are registered
// and appear one cycle after the line bit that causes them.
module hdlc_rx_deframer
   import hdlc_pkg::*;
#(
   parameter int MAX_BYTES = 64,
   parameter int CNT_W     = $clog2(MAX_BYTES + 2)
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_first,
   output logic       eof,
   output logic       frame_err,
   output logic       abort
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [2:0]       LAST_BIT = 3'd7;

   bit_class_t       bit_class;
   state_t           state, state_nx;
   logic [2:0]       bit_cnt, bit_cnt_nx;     // data bits assembled in current byte
   logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;   // bytes emitted in current frame
   logic [7:0]       shift, shift_nx;
   logic [7:0]       assembled;               // shift register after taking in_bit
   logic [7:0]       byte_data_nx;
   logic             byte_valid_nx, byte_first_nx, eof_nx, frame_err_nx, abort_nx;

   hdlc_bit_classifier u_classifier (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .bit_class (bit_class)
   );

   // First line bit ends up in bit [0]: new bits enter at the MSB and shift down.
   assign assembled = {in_bit, shift[7:1]};

   // State, counters and registered outputs.
   // NOTE: byte_data and shift are reset too; they are small and a defined
   // post-reset byte_data keeps downstream logic deterministic.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HUNT;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_first <= 1'b0;
         eof        <= 1'b0;
         frame_err  <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         byte_cnt   <= byte_cnt_nx;
         shift      <= shift_nx;
         byte_valid <= byte_valid_nx;
         byte_data  <= byte_data_nx;
         byte_first <= byte_first_nx;
         eof        <= eof_nx;
         frame_err  <= frame_err_nx;
         abort      <= abort_nx;
      end
   end

   // Next-state and next-output logic for the frame FSM.
   always_comb begin
      state_nx      = state;
      bit_cnt_nx    = bit_cnt;
      byte_cnt_nx   = byte_cnt;
      shift_nx      = shift;
      byte_data_nx  = byte_data;
      byte_valid_nx = 1'b0;
      byte_first_nx = 1'b0;
      eof_nx        = 1'b0;
      frame_err_nx  = 1'b0;
      abort_nx      = 1'b0;

      if (in_valid) begin
         unique case (state)
            HUNT: begin
               // Everything except a flag is line idle or noise.
               if (bit_class == BIT_FLAG) begin
                  state_nx    = OPEN;
                  bit_cnt_nx  = '0;
                  byte_cnt_nx = '0;
               end
            end

            OPEN, DATA: begin
               unique case (bit_class)
                  BIT_FLAG: begin
                     // In OPEN this is an idle or back-to-back flag. In DATA it
                     // closes the frame; the seven flag bits already shifted in
                     // are dropped, so an aligned close leaves bit_cnt at 7.
                     if (state == DATA) begin
                        eof_nx       = 1'b1;
                        frame_err_nx = (bit_cnt != LAST_BIT);
                     end
                     state_nx    = OPEN;
                     bit_cnt_nx  = '0;
                     byte_cnt_nx = '0;
                  end

                  BIT_ABORT: begin
                     // Aborting before any byte left the block is silent.
                     abort_nx = (state == DATA);
                     state_nx = HUNT;
                  end

                  BIT_STUFF: begin
                     // Inserted by the transmitter; not part of the payload.
                  end

                  BIT_DATA: begin
                     shift_nx   = assembled;
                     bit_cnt_nx = bit_cnt + 3'd1;   // wraps to 0 on byte completion
                     if (bit_cnt == LAST_BIT) begin
                        if (state == OPEN) begin
                           byte_valid_nx = 1'b1;
                           byte_first_nx = 1'b1;
                           byte_data_nx  = assembled;
                           byte_cnt_nx   = CNT_W'(1);
                           state_nx      = DATA;
                        end else if (byte_cnt == MAX_CNT) begin
                           // One byte too many: drop it and kill the frame.
                           abort_nx = 1'b1;
                           state_nx = HUNT;
                        end else begin
                           byte_valid_nx = 1'b1;
                           byte_data_nx  = assembled;
                           byte_cnt_nx   = byte_cnt + CNT_W'(1);
                        end
                     end
                  end

                  default: ;
               endcase
            end

            default: state_nx = HUNT;
         endcase
      end
   end

endmodule : hdlc_rx_deframer

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: directed scenarios followed by
// randomized frames, compared cycle by cycle with a bit-level reference model.
module tb_hdlc_rx_deframer;

   localparam int MAX_BYTES = 64;
   localparam int CNT_W     = $clog2(MAX_BYTES + 2);

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_bit;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_first;
   logic       eof;
   logic       frame_err;
   logic       abort;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hdlc_rx_deframer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_first (byte_first),
      .eof        (eof),
      .frame_err  (frame_err),
      .abort      (abort)
   );

   // Reference model: run of ones, whether a frame is open, whether a byte
   // has been delivered in it, and the payload bits collected so far.
   int         m_ones;
   bit         m_in_frame;
   bit         m_no_byte_yet;
   bit         m_bits[$];
   int         m_nbytes;
   logic [7:0] m_last;

   // Expected outputs for the cycle after the bit just driven.
   logic       e_valid, e_first, e_eof, e_err, e_abort;
   logic [7:0] e_data;

   // Transmit-side ones run, used to stuff zeros into generated bytes.
   int    tx_ones;
   int    stall_pct;
   string phase;

   // Observed pulse counts per scenario.
   int obs_bytes, obs_eof, obs_abort, obs_err, obs_first;

   function automatic void clear_expect();
      e_valid = 1'b0;
      e_first = 1'b0;
      e_eof   = 1'b0;
      e_err   = 1'b0;
      e_abort = 1'b0;
      e_data  = m_last;
   endfunction

   function automatic void model_reset();
      m_ones        = 0;
      m_in_frame    = 1'b0;
      m_no_byte_yet = 1'b1;
      m_bits.delete();
      m_nbytes      = 0;
      m_last        = 8'h00;
      tx_ones       = 0;
      clear_expect();
   endfunction

   function automatic void model_open();
      m_in_frame    = 1'b1;
      m_no_byte_yet = 1'b1;
      m_bits.delete();
      m_nbytes      = 0;
   endfunction

   // Apply the line rules to one valid bit.
   function automatic void model_step(input logic b);
      int         prev;
      logic [7:0] v;
      prev = m_ones;
      clear_expect();
      m_ones = b ? ((m_ones < 7) ? m_ones + 1 : 7) : 0;
      if (!m_in_frame) begin
         if (!b && prev == 6) model_open();
      end else if (!b && prev == 6) begin
         if (!m_no_byte_yet) begin
            e_eof = 1'b1;
            e_err = (m_bits.size() != 7);
         end
         model_open();
      end else if (b && prev == 6) begin
         e_abort    = !m_no_byte_yet;
         m_in_frame = 1'b0;
      end else if (!b && prev == 5) begin
         // stuffed zero: dropped
      end else begin
         m_bits.push_back(b);
         if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) v[i] = m_bits[i];
            m_bits.delete();
            if (m_nbytes == MAX_BYTES) begin
               e_abort    = 1'b1;
               m_in_frame = 1'b0;
            end else begin
               e_valid       = 1'b1;
               e_first       = m_no_byte_yet;
               e_data        = v;
               m_last        = v;
               m_no_byte_yet = 1'b0;
               m_nbytes++;
            end
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic compare();
      check("byte_valid", byte_valid, e_valid);
      check("byte_data",  byte_data,  e_data);
      check("byte_first", byte_first, e_first);
      check("eof",        eof,        e_eof);
      check("frame_err",  frame_err,  e_err);
      check("abort",      abort,      e_abort);
      if (byte_valid === 1'b1) obs_bytes++;
      if (byte_valid === 1'b1 && byte_first === 1'b1) obs_first++;
      if (eof === 1'b1) obs_eof++;
      if (eof === 1'b1 && frame_err === 1'b1) obs_err++;
      if (abort === 1'b1) obs_abort++;
   endtask

   task automatic clear_counts();
      obs_bytes = 0;
      obs_first = 0;
      obs_eof   = 0;
      obs_err   = 0;
      obs_abort = 0;
   endtask

   task automatic stall();
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      clear_expect();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic send_raw(input logic b);
      if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) stall();
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = b;
      model_step(b);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic send_flag();
      send_raw(1'b0);
      repeat (6) send_raw(1'b1);
      send_raw(1'b0);
      tx_ones = 0;
   endtask

   // Byte LSB-first with a zero inserted after every fifth consecutive one.
   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         send_raw(v[i]);
         if (v[i]) begin
            tx_ones++;
            if (tx_ones == 5) begin
               send_raw(1'b0);
               tx_ones = 0;
            end
         end else begin
            tx_ones = 0;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b1;
      model_reset();
      repeat (cycles) begin
         @(posedge clk);
         #1;
         compare();
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_bit    = 1'b1;
      stall_pct = 0;
      clear_counts();

      phase = "reset";
      do_reset(3);

      // 1: single byte frame
      phase = "simple";
      clear_counts();
      send_flag();
      send_byte(8'hA5);
      send_flag();
      check("n_bytes", obs_bytes, 1);
      check("n_first", obs_first, 1);
      check("n_eof",   obs_eof,   1);
      check("n_abort", obs_abort, 0);

      // 2: stuffed zero inside 0x3E
      phase = "stuffed";
      clear_counts();
      send_flag();
      send_byte(8'h3E);
      send_flag();
      check("n_bytes", obs_bytes, 1);
      check("n_eof",   obs_eof,   1);
      check("n_err",   obs_err,   0);

      // 3: abort then reopen
      phase = "abort";
      clear_counts();
      send_flag();
      send_byte(8'h11);
      repeat (27) send_raw(1'b1);
      send_flag();
      check("n_abort", obs_abort, 1);
      check("n_eof",   obs_eof,   0);
      send_byte(8'h42);
      send_flag();
      check("n_first", obs_first, 2);
      check("n_eof2",  obs_eof,   1);

      // 4: misaligned close
      phase = "misaligned";
      clear_counts();
      send_flag();
      send_byte(8'h55);
      send_raw(1'b1);
      send_raw(1'b0);
      send_raw(1'b0);
      send_flag();
      check("n_eof", obs_eof, 1);
      check("n_err", obs_err, 1);

      // 5: idle flags then overflow
      phase = "overflow";
      clear_counts();
      send_flag();
      send_flag();
      send_flag();
      check("idle_eof", obs_eof, 0);
      repeat (MAX_BYTES + 1) send_byte(8'h00);
      check("n_bytes", obs_bytes, MAX_BYTES);
      check("n_abort", obs_abort, 1);
      send_byte(8'h81);
      send_byte(8'h7E);
      check("hunt_bytes", obs_bytes, MAX_BYTES);

      // 6: alternate-cycle stalls, then reset mid-byte
      phase = "stall";
      clear_counts();
      stall_pct = 100;
      send_flag();
      send_byte(8'hA5);
      send_flag();
      check("n_bytes", obs_bytes, 1);
      check("n_eof",   obs_eof,   1);
      stall_pct = 0;
      send_flag();
      send_raw(1'b1);
      send_raw(1'b0);
      send_raw(1'b1);
      send_raw(1'b1);
      phase = "mid_reset";
      do_reset(2);
      clear_counts();
      repeat (10) send_raw(1'b0);
      check("post_reset_quiet", obs_bytes + obs_eof + obs_abort, 0);
      send_flag();
      send_byte(8'hC3);
      check("post_reset_first", obs_first, 1);

      // Randomized frames with random stalls, junk bits and aborts.
      phase = "random";
      stall_pct = 25;
      for (int f = 0; f < 30; f++) begin
         send_flag();
         n = ($urandom_range(0, 7) == 0) ? MAX_BYTES + 1 : $urandom_range(0, 12);
         for (int k = 0; k < n; k++) send_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 7)) send_raw(1'($urandom));
         end
         if ($urandom_range(0, 5) == 0) repeat (7) send_raw(1'b1);
         send_flag();
      end
      stall_pct = 0;
      send_raw(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hdlc_rx_deframer
